// File: rtl/pd_pkg.sv
// Shared types and constants for the PD/PI controller slice.
// State encoding, pipeline latency and overrun counter width.
package pd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } pd_state_t;

  localparam int PD_PIPE_LATENCY = 4;
  localparam int OVR_W = 16;

endpackage

// File: rtl/pd_pipeline.sv
// Four-stage PD/PI arithmetic pipeline: error, integral, products, sum.
// Ports: kp/ki/setpoint/actual (IW), integral in, integral_result/pd_result.
module pd_pipeline #(
  parameter int IW = 18,
  parameter int OW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [IW-1:0] kp,
  input  logic signed [IW-1:0] ki,
  input  logic signed [IW-1:0] setpoint,
  input  logic signed [IW-1:0] actual,
  input  logic signed [OW-1:0] integral,
  output logic signed [OW-1:0] integral_result,
  output logic signed [OW-1:0] pd_result
);

  function automatic logic signed [OW-1:0] sext(
    input logic signed [IW-1:0] v
  );
    return {{(OW-IW){v[IW-1]}}, v};
  endfunction

  logic signed [OW-1:0] err1, err2;
  logic signed [OW-1:0] int2, int3, int4;
  logic signed [OW-1:0] pi3, pp3, pd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err1 <= '0;
      err2 <= '0;
      int2 <= '0;
      int3 <= '0;
      int4 <= '0;
      pi3  <= '0;
      pp3  <= '0;
      pd4  <= '0;
    end else begin
      err1 <= sext(actual) - sext(setpoint);
      int2 <= integral + err1;
      err2 <= err1;
      pi3  <= int2 * sext(ki);
      pp3  <= err2 * sext(kp);
      int3 <= int2;
      pd4  <= pi3 + pp3;
      int4 <= int3;
    end
  end

  assign integral_result = int4;
  assign pd_result       = pd4;

endmodule

// File: rtl/pd_controller.sv
// PD/PI sequencing controller: launch, wait pipeline, hold result.
// Ports: sample/gains in, out_valid/out_ready/out_data, integral, overruns.
// Optional: PD_CONTROLLER_ANTI_WINDUP_EN clamps the stored integral.
module pd_controller
  import pd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 18,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int INTEGRAL_LIMIT = 2**24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear_integral,
  input  logic [INPUT_WIDTH-1:0]  kp_in,
  input  logic [INPUT_WIDTH-1:0]  ki_in,
  input  logic [INPUT_WIDTH-1:0]  setpoint_in,
  input  logic                    sample_valid,
  input  logic [INPUT_WIDTH-1:0]  sample,
  output logic                    sample_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic [OUTPUT_WIDTH-1:0] integral_out,
  output logic                    integral_sat,
  output logic                    busy,
  output logic [OVR_W-1:0]        overrun_count
);

  localparam int IW = INPUT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam logic signed [OW-1:0] LIM = OW'(INTEGRAL_LIMIT);

  pd_state_t state;
  logic [2:0] cnt;

  logic signed [IW-1:0] kp_q, ki_q, sp_q, act_q;
  // Integral snapshot at launch so a same-cycle clear
  // does not disturb the sample already in flight.
  logic signed [OW-1:0] int_l;

  logic signed [OW-1:0] int_res, pd_res;
  logic signed [OW-1:0] int_next;
  logic                 sat_next;

  pd_pipeline #(
    .IW(IW),
    .OW(OW)
  ) u_pipe (
    .clk             (clk),
    .rst_n           (rst_n),
    .kp              (kp_q),
    .ki              (ki_q),
    .setpoint        (sp_q),
    .actual          (act_q),
    .integral        (int_l),
    .integral_result (int_res),
    .pd_result       (pd_res)
  );

`ifdef PD_CONTROLLER_ANTI_WINDUP_EN
  always_comb begin
    int_next = int_res;
    sat_next = 1'b0;
    if (int_res > LIM) begin
      int_next = LIM;
      sat_next = 1'b1;
    end else if (int_res < -LIM) begin
      int_next = -LIM;
      sat_next = 1'b1;
    end
  end
`else
  logic unused_lim;
  assign unused_lim = ^LIM;
  assign int_next   = int_res;
  assign sat_next   = 1'b0;
`endif

  assign sample_ready = (state == IDLE) && enable;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      integral_out <= '0;
      integral_sat <= 1'b0;
      kp_q         <= '0;
      ki_q         <= '0;
      sp_q         <= '0;
      act_q        <= '0;
      int_l        <= '0;
    end else if (!enable) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      integral_out <= '0;
      integral_sat <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_valid) begin
            kp_q  <= kp_in;
            ki_q  <= ki_in;
            sp_q  <= setpoint_in;
            act_q <= sample;
            int_l <= integral_out;
            cnt   <= 3'(PD_PIPE_LATENCY);
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            out_data     <= pd_res;
            integral_out <= int_next;
            integral_sat <= sat_next;
            out_valid    <= 1'b1;
            state        <= HOLD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (clear_integral) integral_out <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_count <= '0;
    end else if (enable && sample_valid && !sample_ready &&
                 overrun_count != '1) begin
      overrun_count <= overrun_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pd_controller.sv
// Directed testbench for pd_controller.
// Hand-computed vectors; summary line at end.
module tb_pd_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear_integral;
  logic [17:0] kp_in, ki_in, setpoint_in, sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] integral_out;
  logic        integral_sat;
  logic        busy;
  logic [15:0] overrun_count;

  int n_tests = 0;
  int n_fail  = 0;

  pd_controller #(
    .INPUT_WIDTH(18),
    .OUTPUT_WIDTH(32),
    .INTEGRAL_LIMIT(15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .clear_integral (clear_integral),
    .kp_in          (kp_in),
    .ki_in          (ki_in),
    .setpoint_in    (setpoint_in),
    .sample_valid   (sample_valid),
    .sample         (sample),
    .sample_ready   (sample_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .integral_out   (integral_out),
    .integral_sat   (integral_sat),
    .busy           (busy),
    .overrun_count  (overrun_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_std();
    kp_in       = 18'd2;
    ki_in       = 18'd1;
    setpoint_in = 18'd100;
    sample      = 18'd110;
  endtask

  task automatic accept();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({out_valid, busy, integral_sat} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000",
               {out_valid, busy, integral_sat});
    end
    n_tests++;
    if (out_data !== 32'd0 || integral_out !== 32'd0 ||
        overrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d/%0d/%0d expected 0/0/0",
               out_data, integral_out, overrun_count);
    end
  endtask

  task automatic test_basic();
    int cyc;
    set_std();
    accept();
    wait_valid(cyc);
    n_tests++;
    if (cyc !== 5) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 5", cyc);
    end
    n_tests++;
    if (out_data !== 32'd30 || integral_out !== 32'd10) begin
      n_fail++;
      $display("FAIL basic_result: got %0d/%0d expected 30/10",
               out_data, integral_out);
    end
    release_hold();
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: got busy=%b ov=%b expected 0 0",
               busy, out_valid);
    end
  endtask

  task automatic test_accumulate();
    int acc[$];
    logic [31:0] d1, i1;
    logic got;
    got = 1'b0;
    d1 = '0;
    i1 = '0;
    out_ready = 1'b1;
    sample_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (sample_ready) acc.push_back(c);
      step();
      if (out_valid && !got) begin
        got = 1'b1;
        d1 = out_data;
        i1 = integral_out;
      end
    end
    sample_valid = 1'b0;
    for (int c = 0; c < 8; c++) step();
    out_ready = 1'b0;
    n_tests++;
    if (d1 !== 32'd40 || i1 !== 32'd20) begin
      n_fail++;
      $display("FAIL accum_result: got %0d/%0d expected 40/20", d1, i1);
    end
    n_tests++;
    if (acc.size() < 2 || acc[1] - acc[0] != 7) begin
      n_fail++;
      $display("FAIL accum_period: got %0d accepts expected 7 spacing",
               acc.size());
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic stable;
    do_reset();
    set_std();
    accept();
    wait_valid(cyc);
    stable = 1'b1;
    sample_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_data !== 32'd30 || out_valid !== 1'b1) stable = 1'b0;
    end
    sample_valid = 1'b0;
    n_tests++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d expected 30 held", out_data);
    end
    n_tests++;
    if (overrun_count !== 16'd10) begin
      n_fail++;
      $display("FAIL bp_overrun: got %0d expected 10", overrun_count);
    end
    release_hold();
  endtask

  task automatic test_anti_windup();
    int cyc;
    logic [31:0] exp_i;
    logic exp_s;
`ifdef PD_CONTROLLER_ANTI_WINDUP_EN
    exp_i = 32'd15;
    exp_s = 1'b1;
`else
    exp_i = 32'd20;
    exp_s = 1'b0;
`endif
    set_std();
    accept();
    wait_valid(cyc);
    n_tests++;
    if (out_data !== 32'd40) begin
      n_fail++;
      $display("FAIL aw_out: got %0d expected 40", out_data);
    end
    n_tests++;
    if (integral_out !== exp_i || integral_sat !== exp_s) begin
      n_fail++;
      $display("FAIL aw_state: got %0d sat=%b expected %0d sat=%b",
               integral_out, integral_sat, exp_i, exp_s);
    end
    release_hold();
  endtask

  task automatic test_enable_drop();
    int cyc;
    logic seen;
    set_std();
    accept();
    step();
    step();
    enable = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 ||
        integral_out !== 32'd0) begin
      n_fail++;
      $display("FAIL en_drop: got busy=%b ov=%b int=%0d expected 0 0 0",
               busy, out_valid, integral_out);
    end
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL en_discard: got out_valid=1 expected 0");
    end
    accept();
    wait_valid(cyc);
    n_tests++;
    if (out_data !== 32'd30 || integral_out !== 32'd10) begin
      n_fail++;
      $display("FAIL en_restart: got %0d/%0d expected 30/10",
               out_data, integral_out);
    end
    release_hold();
  endtask

  task automatic test_negative();
    int cyc;
    logic [31:0] exp_i;
    logic exp_s;
`ifdef PD_CONTROLLER_ANTI_WINDUP_EN
    exp_i = -32'sd15;
    exp_s = 1'b1;
`else
    exp_i = -32'sd20;
    exp_s = 1'b0;
`endif
    kp_in       = 18'd3;
    ki_in       = -18'sd2;
    setpoint_in = 18'd50;
    sample      = 18'd20;
    accept();
    wait_valid(cyc);
    n_tests++;
    if (out_data !== -32'sd50) begin
      n_fail++;
      $display("FAIL neg_out: got %0d expected -50", $signed(out_data));
    end
    n_tests++;
    if (integral_out !== exp_i || integral_sat !== exp_s) begin
      n_fail++;
      $display("FAIL neg_state: got %0d sat=%b expected %0d sat=%b",
               $signed(integral_out), integral_sat,
               $signed(exp_i), exp_s);
    end
    release_hold();
  endtask

  task automatic test_clear_on_capture();
    logic [31:0] exp_d;
`ifdef PD_CONTROLLER_ANTI_WINDUP_EN
    exp_d = 32'd15;
`else
    exp_d = 32'd10;
`endif
    set_std();
    accept();
    for (int k = 0; k < 4; k++) step();
    clear_integral = 1'b1;
    step();
    clear_integral = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== exp_d) begin
      n_fail++;
      $display("FAIL clr_out: got ov=%b %0d expected 1 %0d",
               out_valid, out_data, exp_d);
    end
    n_tests++;
    if (integral_out !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_int: got %0d expected 0", integral_out);
    end
  endtask

  task automatic test_mid_reset();
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, busy, integral_sat} !== 3'b000 ||
        out_data !== 32'd0 || integral_out !== 32'd0 ||
        overrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got ov=%b d=%0d i=%0d ovr=%0d expected 0",
               out_valid, out_data, integral_out, overrun_count);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b1;
    clear_integral = 1'b0;
    sample_valid   = 1'b0;
    out_ready      = 1'b0;
    set_std();
    test_reset();
    test_basic();
    test_accumulate();
    test_backpressure();
    test_anti_windup();
    test_enable_drop();
    test_negative();
    test_clear_on_capture();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pd_controller.md
# pd_controller

Sequencing controller for the PD/PI arithmetic pipeline. It accepts one measurement sample at a time from the ADC side and latches gains and setpoint so they stay stable for the whole computation. It owns the running integral state, waits out the pipeline latency, and presents a registered controller output with a valid/ready handshake toward the DAC/output side.

## Interface
- INPUT_WIDTH, 18: width of gains, setpoint and sample (signed).
- OUTPUT_WIDTH, 32: width of integral state and controller output (signed).
- INTEGRAL_LIMIT, 2**24: positive clamp magnitude for the integral; only used with anti-windup compiled in.
- clk  in  1  system clock; the block has one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  loop enable; low forces IDLE and clears the integral.
- clear_integral  in  1  single-cycle request to zero the integral state.
- kp_in, ki_in  in  INPUT_WIDTH  gains, sampled at launch.
- setpoint_in  in  INPUT_WIDTH  setpoint, sampled at launch.
- sample_valid  in  1  measurement valid.
- sample  in  INPUT_WIDTH  measurement (actual).
- sample_ready  out  1  high when state==IDLE and enable is high (combinational).
- out_valid  out  1  controller result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUTPUT_WIDTH  registered controller result.
- integral_out  out  OUTPUT_WIDTH  current integral state.
- integral_sat  out  1  last capture clamped the integral (tied 0 without the macro).
- busy  out  1  state is not IDLE.
- overrun_count  out  16  dropped-sample counter, saturating.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: on sample_valid && sample_ready, latch kp, ki, setpoint and sample into launch registers. Load cnt=PD_PIPE_LATENCY (4) and go to RUN.
- RUN: cnt decrements each cycle. When cnt==0:
  - out_data <= pipeline pd_result.
  - Integral state <= pipeline integral_result, clamped if the macro is enabled.
  - Go to HOLD.
- HOLD: out_valid=1, with out_data and integral_out stable. On out_ready, go to IDLE.
- Pipeline semantics: error = actual − setpoint, sign-extended to OUTPUT_WIDTH. integral' = integral + error. result = integral'·ki + error·kp. The products are truncated to OUTPUT_WIDTH, two's-complement wrap.
- The pipeline integral input is driven from the integral state register. Launch registers are held constant through RUN.
- The pd_result of a sample uses the unclamped integral'. Clamping applies only to the stored state.
- Overrun: enable && sample_valid && !sample_ready increments overrun_count each cycle. It saturates at 0xFFFF and is cleared only by reset.
- enable low in any state: next state IDLE, out_valid 0, integral 0, integral_sat 0. Any in-flight result is discarded. overrun_count does not count.
- clear_integral:
  - Zeroes the integral at the next edge in any state.
  - If it coincides with the RUN capture edge, clear wins over the captured integral. out_data is still captured.
  - If it is asserted in the same cycle as a launch, the integral is zeroed and the sample already in flight uses the pre-clear value.

## Timing
- Reset values (rst_n low at an edge): state IDLE, out_valid 0, out_data 0, integral_out 0, integral_sat 0, overrun_count 0, launch registers 0. busy is therefore 0.
- Accept at edge N.
  - Pipeline error is valid after N+1, integral after N+2, products after N+3, pd_result after N+4.
  - Capture occurs at edge N+5, so out_valid is high from N+5.
- Minimum sample period is 7 cycles, with out_ready held high: accept N, HOLD N+5, IDLE N+6, next accept N+7.
- HOLD persists indefinitely while out_ready is low. Samples offered during that time are counted as overruns.

## Configuration
- PD_CONTROLLER_ANTI_WINDUP_EN defined: on capture, the integral is clamped to [−INTEGRAL_LIMIT, +INTEGRAL_LIMIT]. integral_sat is set to 1 if clamping occurred, else 0, and updates on every capture.
- PD_CONTROLLER_ANTI_WINDUP_EN undefined: the integral wraps modulo 2^OUTPUT_WIDTH and integral_sat is constant 0.

## Structure
- Shared package pd_pkg contains:
  - the state enum (IDLE, RUN, HOLD);
  - PD_PIPE_LATENCY=4;
  - the overrun counter width constant 16.
- One sub-module, pd_pipeline, is instantiated internally and driven from the launch registers and the integral state.

## Test plan
- Basic: kp=2, ki=1, setpoint=100, sample=110, integral 0. Expect out_valid 5 cycles after accept, out_data=30, integral_out=10.
- Accumulate: repeat the same sample with out_ready high. Expect out_data=40, integral_out=20, and the second accept no earlier than 7 cycles after the first.
- Backpressure/overrun: out_ready low for 10 cycles in HOLD while sample_valid is high. Expect out_data stable and overrun_count=10.
- Anti-windup (macro on, INTEGRAL_LIMIT=15): two samples of error 10. Expect the second out_data=40, integral_out=15, integral_sat=1. With the macro off, expect integral_out=20 and integral_sat=0.
- Enable drop at N+3 of a run: expect IDLE next cycle, no out_valid, integral 0. The next sample computes from integral 0.
- clear_integral on the capture edge: expect out_data captured normally and integral_out=0; a mid-cycle rst_n low returns all outputs to reset values.
